jelly_rasterizer_scan_gen: RTL and testbench
============================================

// Module: jelly_rasterizer_scan_gen
// PURPOSE
//  Raster scan sequencer feeding jelly_rasterizer_plane_calc instances (edge and colour planes).
//  On a start strobe it latches the frame size and walks pixels row-major: x from 0 to X_NUM-1,
//  then y from 0 to Y_NUM-1. Per pixel it emits coordinates, x_first/y_first, and
//  valid/ready flow control. It also drives the calc stages' reset and cke so they advance in lockstep.
// PARAMETERS
//  X_WIDTH   10   width of x coordinate / x size register
//  Y_WIDTH    9   width of y coordinate / y size register
// PORTS
//  reset_n        in   1        asynchronous reset, active low
//  clk            in   1        single clock for the whole block
//  param_x_num_m1 in   X_WIDTH  frame width minus 1; sampled only when start is accepted
//  param_y_num_m1 in   Y_WIDTH  frame height minus 1; sampled only when start is accepted
//  start          in   1        1-cycle frame start request
//  abort          in   1        terminate current frame at once
//  busy           out  1        frame in progress
//  frame_end      out  1        1-cycle pulse after the last pixel is accepted
//  m_x            out  X_WIDTH  pixel x
//  m_y            out  Y_WIDTH  pixel y
//  m_x_first      out  1        m_x == 0
//  m_y_first      out  1        m_y == 0
//  m_last         out  1        last pixel of the frame
//  m_valid        out  1        pixel valid
//  m_ready        in   1        downstream accepts pixel
//  calc_reset     out  1        reset for plane_calc; high whenever no frame is active
//  calc_cke       out  1        cke for plane_calc = !m_valid | m_ready (combinational)
// BEHAVIOUR
//  - Reset values (async, reset_n=0): state IDLE; busy=0, frame_end=0, m_valid=0, m_x=0, m_y=0,
//    m_x_first=1, m_y_first=1, m_last=0, calc_reset=1. All outputs are registered except calc_cke.
//  - States:
//    IDLE: accepts start when abort=0. Next cycle -> RUN with m_valid=1, x=y=0, busy=1, calc_reset=0.
//    RUN: holds m_x, m_y, m_valid while m_valid & !m_ready (no change under stall).
//      On a transfer (m_valid & m_ready):
//        - x < xm1: x++.
//        - x == xm1 and y < ym1: x=0, y++.
//        - x == xm1 and y == ym1: -> IDLE; m_valid=0; busy=0; calc_reset=1; frame_end=1 for
//          exactly one cycle; m_x and m_y return to 0.
//  - m_x_first, m_y_first and m_last are registered. They always match the m_x/m_y they accompany.
//    m_last = (x==xm1 && y==ym1).
//  - xm1 and ym1 are internal copies latched on start. Port changes during RUN are ignored.
//  - Start in RUN is ignored; it is not queued.
//  - Abort, in any state:
//    - next cycle: IDLE, m_valid=0, busy=0, calc_reset=1, no frame_end.
//    - Overrides a simultaneous start and a simultaneous last transfer (no frame_end then).
//  - Degenerate sizes:
//    - xm1=0: every pixel has m_x_first=1.
//    - xm1=ym1=0: one pixel, m_last=1 on it.
//  - Back-to-back frames: start asserted in the frame_end cycle is accepted (state is IDLE).
//    m_valid rises the next cycle, giving exactly one invalid cycle between frames.
//  - Coordinate counters never exceed xm1/ym1. There is no wrap beyond the latched size.
//  - Reset asserted mid-frame clears everything immediately. No frame_end is produced.
// TESTING
//  1. xm1=3, ym1=2, m_ready=1, start pulse:
//     -> 12 pixels on consecutive cycles starting 1 cycle after start.
//     -> x_first on pixels 0,4,8; y_first on pixels 0-3; m_last on pixel 11;
//        frame_end on the following cycle.
//  2. Same size, m_ready toggled pseudo-randomly:
//     -> identical (x,y) sequence; values stable during stalls; calc_cke=0 exactly on stall cycles.
//  3. Abort at pixel (2,1) while stalled:
//     -> m_valid=0 and calc_reset=1 next cycle; frame_end never pulses; new start then begins at (0,0).
//  4. xm1=ym1=0:
//     -> single pixel with x_first=y_first=m_last=1, then frame_end.
//     Also: start held high during RUN -> no restart.
//  5. Change param_x_num_m1 mid-frame, then start asserted in the frame_end cycle:
//     -> old size used for frame 1; new frame starts after a 1-cycle gap, with the sampled new size.
//  6. reset_n pulsed low mid-frame (not clock-aligned):
//     -> outputs at reset values immediately; after release, idle until start.

Source files
------------

// File: rtl/jelly_rasterizer_scan_gen.sv
// rtl/jelly_rasterizer_scan_gen.sv - row-major raster scan sequencer driving plane_calc stages
module jelly_rasterizer_scan_gen #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
) (
    input  logic               reset_n,
    input  logic               clk,

    input  logic [X_WIDTH-1:0] param_x_num_m1,
    input  logic [Y_WIDTH-1:0] param_y_num_m1,

    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               frame_end,

    output logic [X_WIDTH-1:0] m_x,
    output logic [Y_WIDTH-1:0] m_y,
    output logic               m_x_first,
    output logic               m_y_first,
    output logic               m_last,
    output logic               m_valid,
    input  logic               m_ready,

    output logic               calc_reset,
    output logic               calc_cke
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state, state_next;

    logic [X_WIDTH-1:0] xm1, xm1_next;
    logic [Y_WIDTH-1:0] ym1, ym1_next;
    logic [X_WIDTH-1:0] x_next;
    logic [Y_WIDTH-1:0] y_next;
    logic               x_first_next;
    logic               y_first_next;
    logic               last_next;
    logic               valid_next;
    logic               busy_next;
    logic               frame_end_next;
    logic               calc_reset_next;

    logic [X_WIDTH-1:0] x_inc;
    logic [Y_WIDTH-1:0] y_inc;
    logic               x_at_end;
    logic               y_at_end;

    assign x_inc    = m_x + X_WIDTH'(1);
    assign y_inc    = m_y + Y_WIDTH'(1);
    assign x_at_end = (m_x == xm1);
    assign y_at_end = (m_y == ym1);

    // The calc pipeline advances whenever the current pixel is empty or being taken.
    assign calc_cke = !m_valid | m_ready;

    // Next-state and next-output decode; abort dominates every other event.
    always_comb begin
        state_next      = state;
        xm1_next        = xm1;
        ym1_next        = ym1;
        x_next          = m_x;
        y_next          = m_y;
        x_first_next    = m_x_first;
        y_first_next    = m_y_first;
        last_next       = m_last;
        valid_next      = m_valid;
        busy_next       = busy;
        frame_end_next  = 1'b0;
        calc_reset_next = calc_reset;

        if (abort) begin
            state_next      = ST_IDLE;
            x_next          = '0;
            y_next          = '0;
            x_first_next    = 1'b1;
            y_first_next    = 1'b1;
            last_next       = 1'b0;
            valid_next      = 1'b0;
            busy_next       = 1'b0;
            calc_reset_next = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next      = ST_RUN;
                        xm1_next        = param_x_num_m1;
                        ym1_next        = param_y_num_m1;
                        x_next          = '0;
                        y_next          = '0;
                        x_first_next    = 1'b1;
                        y_first_next    = 1'b1;
                        last_next       = (param_x_num_m1 == '0) && (param_y_num_m1 == '0);
                        valid_next      = 1'b1;
                        busy_next       = 1'b1;
                        calc_reset_next = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (m_valid && m_ready) begin
                        if (!x_at_end) begin
                            x_next       = x_inc;
                            x_first_next = 1'b0;
                            last_next    = (x_inc == xm1) && y_at_end;
                        end else if (!y_at_end) begin
                            x_next       = '0;
                            y_next       = y_inc;
                            x_first_next = 1'b1;
                            y_first_next = 1'b0;
                            last_next    = (xm1 == '0) && (y_inc == ym1);
                        end else begin
                            state_next      = ST_IDLE;
                            x_next          = '0;
                            y_next          = '0;
                            x_first_next    = 1'b1;
                            y_first_next    = 1'b1;
                            last_next       = 1'b0;
                            valid_next      = 1'b0;
                            busy_next       = 1'b0;
                            frame_end_next  = 1'b1;
                            calc_reset_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; async reset returns to the idle frame state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            xm1        <= '0;
            ym1        <= '0;
            m_x        <= '0;
            m_y        <= '0;
            m_x_first  <= 1'b1;
            m_y_first  <= 1'b1;
            m_last     <= 1'b0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            frame_end  <= 1'b0;
            calc_reset <= 1'b1;
        end else begin
            state      <= state_next;
            xm1        <= xm1_next;
            ym1        <= ym1_next;
            m_x        <= x_next;
            m_y        <= y_next;
            m_x_first  <= x_first_next;
            m_y_first  <= y_first_next;
            m_last     <= last_next;
            m_valid    <= valid_next;
            busy       <= busy_next;
            frame_end  <= frame_end_next;
            calc_reset <= calc_reset_next;
        end
    end

endmodule

// File: tb/tb_jelly_rasterizer_scan_gen.sv
// tb/tb_jelly_rasterizer_scan_gen.sv - directed self-checking bench for jelly_rasterizer_scan_gen
module tb_jelly_rasterizer_scan_gen;

    localparam int XW = 10;
    localparam int YW = 9;

    logic          reset_n;
    logic          clk;
    logic [XW-1:0] param_x_num_m1;
    logic [YW-1:0] param_y_num_m1;
    logic          start;
    logic          abort;
    logic          busy;
    logic          frame_end;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic          m_x_first;
    logic          m_y_first;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          calc_reset;
    logic          calc_cke;

    int n_checks = 0;
    int n_fail   = 0;

    jelly_rasterizer_scan_gen #(.X_WIDTH(XW), .Y_WIDTH(YW)) dut (
        .reset_n        (reset_n),
        .clk            (clk),
        .param_x_num_m1 (param_x_num_m1),
        .param_y_num_m1 (param_y_num_m1),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .frame_end      (frame_end),
        .m_x            (m_x),
        .m_y            (m_y),
        .m_x_first      (m_x_first),
        .m_y_first      (m_y_first),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .calc_reset     (calc_reset),
        .calc_cke       (calc_cke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flag vector order: {m_valid, m_x_first, m_y_first, m_last, busy, calc_reset, frame_end}
    localparam logic [6:0] FLAGS_IDLE      = 7'b0110010;
    localparam logic [6:0] FLAGS_FRAME_END = 7'b0110011;

    function automatic logic [6:0] flags();
        return {m_valid, m_x_first, m_y_first, m_last, busy, calc_reset, frame_end};
    endfunction

    // Runs one frame from idle; each pixel is checked against a row-major walk.
    // chg_x >= 0 rewrites the x-size port after the first transfer; hold_start keeps start high.
    task automatic run_frame(input string tag, input int xm1, input int ym1, input bit rnd,
                             input int chg_x, input bit hold_start);
        int ex, ey, cycles;
        bit rdy, done;
        logic [6:0] exp_flags;
        param_x_num_m1 = XW'(xm1);
        param_y_num_m1 = YW'(ym1);
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        ex = 0; ey = 0; cycles = 0; done = 0;
        while (!done) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready = rdy;
            #1;
            exp_flags = {1'b1, ex == 0, ey == 0, (ex == xm1) && (ey == ym1), 1'b1, 1'b0, 1'b0};
            n_checks++;
            if ({m_x, m_y} !== {XW'(ex), YW'(ey)}) begin
                n_fail++;
                $display("FAIL %s coord: got (%0d,%0d) expected (%0d,%0d)", tag, m_x, m_y, ex, ey);
            end
            n_checks++;
            if (flags() !== exp_flags) begin
                n_fail++;
                $display("FAIL %s flags at (%0d,%0d): got %b expected %b", tag, ex, ey, flags(), exp_flags);
            end
            n_checks++;
            if (calc_cke !== rdy) begin
                n_fail++;
                $display("FAIL %s calc_cke: got %b expected %b", tag, calc_cke, rdy);
            end
            @(negedge clk);
            if (rdy) begin
                if (ex == xm1 && ey == ym1) done = 1;
                else if (ex < xm1) ex++;
                else begin ex = 0; ey++; end
                if (chg_x >= 0) param_x_num_m1 = XW'(chg_x);
            end
            cycles++;
            if (!done && cycles > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: got %0d cycles expected frame completion", tag, cycles);
                done = 1;
            end
        end
        start = 1'b0;
        n_checks++;
        if (flags() !== FLAGS_FRAME_END || m_x !== '0 || m_y !== '0) begin
            n_fail++;
            $display("FAIL %s frame_end: got flags %b (%0d,%0d) expected %b (0,0)",
                     tag, flags(), m_x, m_y, FLAGS_FRAME_END);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; m_ready = 1'b0;
        param_x_num_m1 = '0; param_y_num_m1 = '0;
        @(negedge clk);
        n_checks++;
        if (flags() !== FLAGS_IDLE || m_x !== '0 || m_y !== '0 || calc_cke !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: got flags %b (%0d,%0d) cke %b expected %b (0,0) cke 1",
                     flags(), m_x, m_y, calc_cke, FLAGS_IDLE);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (flags() !== FLAGS_IDLE) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected %b", flags(), FLAGS_IDLE);
        end
    endtask

    task automatic test_basic();
        run_frame("basic", 3, 2, 1'b0, -1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (flags() !== FLAGS_IDLE) begin
            n_fail++;
            $display("FAIL basic_idle: got %b expected %b", flags(), FLAGS_IDLE);
        end
    endtask

    task automatic test_stall();
        run_frame("stall", 3, 2, 1'b1, -1, 1'b0);
        @(negedge clk);
        run_frame("stall_x0", 0, 2, 1'b1, -1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_abort();
        param_x_num_m1 = XW'(3);
        param_y_num_m1 = YW'(2);
        m_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        m_ready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({m_x, m_y} !== {XW'(2), YW'(1)} || m_valid !== 1'b1 || calc_cke !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stall: got (%0d,%0d) v%b cke%b expected (2,1) v1 cke0",
                     m_x, m_y, m_valid, calc_cke);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (flags() !== FLAGS_IDLE) begin
            n_fail++;
            $display("FAIL abort_next: got %b expected %b", flags(), FLAGS_IDLE);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (frame_end !== 1'b0 || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_quiet: got fe%b v%b expected fe0 v0", frame_end, m_valid);
            end
        end
        // abort beats a simultaneous start
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (flags() !== FLAGS_IDLE) begin
            n_fail++;
            $display("FAIL abort_vs_start: got %b expected %b", flags(), FLAGS_IDLE);
        end
        run_frame("after_abort", 3, 2, 1'b0, -1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_single();
        run_frame("single", 0, 0, 1'b0, -1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (flags() !== FLAGS_IDLE) begin
            n_fail++;
            $display("FAIL single_no_restart: got %b expected %b", flags(), FLAGS_IDLE);
        end
        run_frame("hold_start", 1, 1, 1'b0, -1, 1'b1);
        @(negedge clk);
        n_checks++;
        if (flags() !== FLAGS_IDLE) begin
            n_fail++;
            $display("FAIL hold_no_restart: got %b expected %b", flags(), FLAGS_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_old", 3, 2, 1'b0, 1, 1'b0);
        run_frame("b2b_new", 1, 2, 1'b1, -1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        param_x_num_m1 = XW'(3);
        param_y_num_m1 = YW'(2);
        m_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (flags() !== FLAGS_IDLE || m_x !== '0 || m_y !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got flags %b (%0d,%0d) expected %b (0,0)",
                     flags(), m_x, m_y, FLAGS_IDLE);
        end
        #13;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (flags() !== FLAGS_IDLE) begin
                n_fail++;
                $display("FAIL post_reset_idle: got %b expected %b", flags(), FLAGS_IDLE);
            end
        end
        run_frame("post_reset", 2, 1, 1'b0, -1, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
